// File: rtl/jtriders_eeprom_if.sv
// Serial EEPROM pins plus host NVRAM load/save port of the 93C46 emulation.
interface jtriders_eeprom_if;
  logic        eep_cs;
  logic        eep_sk;
  logic        eep_di;
  logic        eep_do;
  logic        eep_rdy;
  logic [5:0]  nv_addr;
  logic [15:0] nv_din;
  logic        nv_we;
  logic [15:0] nv_dout;

  modport master (
    output eep_cs, eep_sk, eep_di, nv_addr, nv_din, nv_we,
    input  eep_do, eep_rdy, nv_dout
  );

  modport slave (
    input  eep_cs, eep_sk, eep_di, nv_addr, nv_din, nv_we,
    output eep_do, eep_rdy, nv_dout
  );
endinterface

// File: rtl/jtriders_eeprom.sv
// 93C46 (64 x 16) serial EEPROM emulation with a host NVRAM port that always
// takes priority over serial programming.
module jtriders_eeprom #(
  parameter int unsigned WR_CYCLES = 2048
) (
  input logic               clk,
  input logic               rst_n,
  jtriders_eeprom_if.slave  bus
);

  localparam int unsigned BW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [BW-1:0] BusyLast = BW'(WR_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StCmd, StRead, StWdata, StBusy} state_e;
  typedef enum logic [2:0] {PgNone, PgWrite, PgWral, PgErase, PgEral} prog_e;

  state_e        state_q, state_d;
  prog_e         kind_q, kind_d;
  logic          sk_q;
  logic [4:0]    cnt_q, cnt_d;
  logic [15:0]   shift_q, shift_d;
  logic [5:0]    addr_q, addr_d;
  logic          ewen_q, ewen_d;
  logic          do_q, do_d;
  logic [BW-1:0] busy_q, busy_d;
  logic [15:0]   nv_dout_q;
  logic [15:0]   mem_q [64];

  logic          sk_rise;
  logic          prog_go;
  logic          prog_all;
  logic [15:0]   prog_data;

  assign sk_rise = bus.eep_sk & ~sk_q & bus.eep_cs;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    ewen_d  = ewen_q;
    do_d    = do_q;
    busy_d  = busy_q;
    prog_go = 1'b0;

    unique case (state_q)
      StIdle: begin
        // An armed ERASE/ERAL waits here for CS to drop.
        if (kind_q != PgNone && !bus.eep_cs) begin
          prog_go = 1'b1;
        end else if (sk_rise && bus.eep_di) begin
          state_d = StCmd;
          cnt_d   = '0;
          kind_d  = PgNone;
        end
      end
      StCmd: begin
        if (!bus.eep_cs) begin
          state_d = StIdle;
        end else if (sk_rise) begin
          shift_d = {shift_q[14:0], bus.eep_di};
          cnt_d   = 5'(cnt_q + 5'd1);
          if (cnt_q == 5'd7) begin
            addr_d = shift_d[5:0];
            cnt_d  = '0;
            unique case (shift_d[7:6])
              2'b10: begin
                state_d = StRead;
                shift_d = mem_q[shift_d[5:0]];
                do_d    = 1'b0;
              end
              2'b01: begin
                state_d = StWdata;
                kind_d  = PgWrite;
              end
              2'b11: begin
                state_d = StIdle;
                kind_d  = ewen_q ? PgErase : PgNone;
              end
              2'b00: begin
                unique case (shift_d[5:4])
                  2'b00: begin
                    state_d = StIdle;
                    ewen_d  = 1'b0;
                  end
                  2'b01: begin
                    state_d = StWdata;
                    kind_d  = PgWral;
                  end
                  2'b10: begin
                    state_d = StIdle;
                    kind_d  = ewen_q ? PgEral : PgNone;
                  end
                  2'b11: begin
                    state_d = StIdle;
                    ewen_d  = 1'b1;
                  end
                endcase
              end
            endcase
          end
        end
      end
      StRead: begin
        if (!bus.eep_cs) begin
          state_d = StIdle;
        end else if (sk_rise) begin
          do_d    = shift_q[15];
          shift_d = {shift_q[14:0], 1'b0};
          cnt_d   = 5'(cnt_q + 5'd1);
          // Bit 0 just went out: reload with the next word so reads stream on.
          if (cnt_q == 5'd15) begin
            addr_d  = 6'(addr_q + 6'd1);
            shift_d = mem_q[6'(addr_q + 6'd1)];
            cnt_d   = '0;
          end
        end
      end
      StWdata: begin
        if (!bus.eep_cs) begin
          if (cnt_q == 5'd16 && ewen_q) begin
            prog_go = 1'b1;
          end else begin
            state_d = StIdle;
            kind_d  = PgNone;
          end
        end else if (sk_rise) begin
          shift_d = {shift_q[14:0], bus.eep_di};
          // Saturate at 17 so any overlong data stream is remembered as invalid.
          if (cnt_q != 5'd17) cnt_d = 5'(cnt_q + 5'd1);
        end
      end
      StBusy: begin
        if (busy_q == BusyLast) begin
          state_d = StIdle;
        end else begin
          busy_d = BW'(busy_q + 1'b1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (prog_go) begin
      state_d = StBusy;
      busy_d  = '0;
      kind_d  = PgNone;
    end

    if (state_d != StRead) do_d = 1'b1;
  end

  assign prog_all  = (kind_q == PgWral) || (kind_q == PgEral);
  assign prog_data = ((kind_q == PgErase) || (kind_q == PgEral)) ? 16'hFFFF : shift_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      kind_q    <= PgNone;
      sk_q      <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      ewen_q    <= 1'b0;
      do_q      <= 1'b1;
      busy_q    <= '0;
      nv_dout_q <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      sk_q      <= bus.eep_sk;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      ewen_q    <= ewen_d;
      do_q      <= do_d;
      busy_q    <= busy_d;
      nv_dout_q <= mem_q[bus.nv_addr];
    end
  end

  // No reset here: contents survive reset; the later host write wins a clash.
  always_ff @(posedge clk) begin
    if (prog_go && rst_n) begin
      if (prog_all) begin
        for (int i = 0; i < 64; i++) mem_q[i] <= prog_data;
      end else begin
        mem_q[addr_q] <= prog_data;
      end
    end
    if (bus.nv_we) mem_q[bus.nv_addr] <= bus.nv_din;
  end

  assign bus.eep_do  = do_q;
  assign bus.eep_rdy = (state_q != StBusy);
  assign bus.nv_dout = nv_dout_q;

endmodule

// File: tb/tb_jtriders_eeprom.sv
// Directed bench for jtriders_eeprom: serial read/write/erase, enable gating,
// malformed commands and reset during programming.
module tb_jtriders_eeprom;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  jtriders_eeprom_if bus ();

  jtriders_eeprom #(.WR_CYCLES(2048)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [5:0] a, input logic [15:0] d);
    bus.nv_addr = a;
    bus.nv_din  = d;
    bus.nv_we   = 1'b1;
    tick();
    bus.nv_we   = 1'b0;
  endtask

  task automatic host_rd(input logic [5:0] a, output logic [15:0] d);
    bus.nv_addr = a;
    tick();
    d = bus.nv_dout;
  endtask

  task automatic sk_bit(input logic b, output logic d);
    bus.eep_di = b;
    bus.eep_sk = 1'b1;
    tick();
    d = bus.eep_do;
    bus.eep_sk = 1'b0;
    tick();
  endtask

  // Raises CS, sends start bit, opcode and address; returns DO after decode.
  task automatic send_cmd(input logic [1:0] op, input logic [5:0] a, output logic d);
    logic x;
    bus.eep_cs = 1'b1;
    tick();
    sk_bit(1'b1, x);
    for (int i = 1; i >= 0; i--) sk_bit(op[i], x);
    for (int i = 5; i >= 0; i--) sk_bit(a[i], x);
    d = x;
  endtask

  task automatic send_data(input logic [15:0] v, input int n);
    logic x;
    for (int i = 0; i < n; i++) sk_bit(v[15-i], x);
  endtask

  task automatic read_bits(input int n, output logic [31:0] v);
    logic x;
    v = '0;
    for (int i = 0; i < n; i++) begin
      sk_bit(1'b0, x);
      v = {v[30:0], x};
    end
  endtask

  task automatic cs_off();
    bus.eep_cs = 1'b0;
    bus.eep_di = 1'b0;
    tick();
  endtask

  // CS must already be low; counts cycles with RDY low, bounded.
  task automatic wait_busy(output int lo, output int do_low);
    lo = 0;
    do_low = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!bus.eep_rdy) begin
        lo++;
        if (!bus.eep_do) do_low++;
      end else if (lo > 0 || i > 4) begin
        break;
      end
    end
  endtask

  task automatic ewen();
    logic x;
    send_cmd(2'b00, 6'b110000, x);
    cs_off();
  endtask

  initial begin
    logic        d;
    logic [15:0] w;
    logic [31:0] v;
    int          lo;
    int          dl;
    int          bad;

    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.eep_cs = 1'b0;
    bus.eep_sk = 1'b0;
    bus.eep_di = 1'b0;
    bus.nv_addr = '0;
    bus.nv_din = '0;
    bus.nv_we = 1'b0;
    tick();
    tick();
    check_eq("reset_rdy", 32'(bus.eep_rdy), 32'd1);
    check_eq("reset_do", 32'(bus.eep_do), 32'd1);
    check_eq("reset_nv_dout", 32'(bus.nv_dout), 32'd0);
    rst_n = 1'b1;
    tick();

    // Serial read with streaming into the next word.
    host_wr(6'd5, 16'h1234);
    host_wr(6'd6, 16'hA5C3);
    host_rd(6'd5, w);
    check_eq("host_rd5", 32'(w), 32'h1234);
    send_cmd(2'b10, 6'd5, d);
    check_eq("read_dummy", 32'(d), 32'd0);
    read_bits(16, v);
    check_eq("read_w5", v, 32'h1234);
    read_bits(16, v);
    check_eq("read_w6", v, 32'hA5C3);
    cs_off();
    check_eq("do_idle", 32'(bus.eep_do), 32'd1);

    // Enabled WRITE: busy length and stored value.
    ewen();
    send_cmd(2'b01, 6'd3, d);
    send_data(16'hBEEF, 16);
    bus.eep_cs = 1'b0;
    wait_busy(lo, dl);
    check_eq("write_busy_len", 32'(lo), 32'd2048);
    check_eq("busy_do_high", 32'(dl), 32'd0);
    host_rd(6'd3, w);
    check_eq("write_w3", 32'(w), 32'hBEEF);

    // After reset write-enable is off: WRITE is dropped.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send_cmd(2'b01, 6'd3, d);
    send_data(16'h0000, 16);
    bus.eep_cs = 1'b0;
    wait_busy(lo, dl);
    check_eq("wds_no_busy", 32'(lo), 32'd0);
    host_rd(6'd3, w);
    check_eq("wds_w3_kept", 32'(w), 32'hBEEF);

    // ERAL then read across the 63 -> 0 wrap.
    ewen();
    send_cmd(2'b00, 6'b100000, d);
    bus.eep_cs = 1'b0;
    wait_busy(lo, dl);
    check_eq("eral_busy_len", 32'(lo), 32'd2048);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      host_rd(6'(i), w);
      if (w !== 16'hFFFF) bad++;
    end
    check_eq("eral_all_ffff", 32'(bad), 32'd0);
    send_cmd(2'b10, 6'd63, d);
    read_bits(17, v);
    check_eq("wrap_read_ffff", v, 32'h1FFFF);
    cs_off();
    host_wr(6'd0, 16'h7FFF);
    host_wr(6'd63, 16'h00F0);
    send_cmd(2'b10, 6'd63, d);
    read_bits(17, v);
    check_eq("wrap_read_msb0", v, 32'h001E0);
    cs_off();

    // Short data stream discarded; aborted command then a clean READ.
    host_wr(6'd7, 16'h1111);
    send_cmd(2'b01, 6'd7, d);
    send_data(16'hFFFF, 10);
    bus.eep_cs = 1'b0;
    wait_busy(lo, dl);
    check_eq("short_no_busy", 32'(lo), 32'd0);
    host_rd(6'd7, w);
    check_eq("short_w7_kept", 32'(w), 32'h1111);
    bus.eep_cs = 1'b1;
    tick();
    sk_bit(1'b1, d);
    sk_bit(1'b1, d);
    sk_bit(1'b0, d);
    sk_bit(1'b0, d);
    cs_off();
    send_cmd(2'b10, 6'd7, d);
    check_eq("abort_dummy", 32'(d), 32'd0);
    read_bits(16, v);
    check_eq("abort_read_w7", v, 32'h1111);
    cs_off();

    // ERASE one word only.
    host_wr(6'd8, 16'h2222);
    send_cmd(2'b11, 6'd7, d);
    bus.eep_cs = 1'b0;
    wait_busy(lo, dl);
    check_eq("erase_busy_len", 32'(lo), 32'd2048);
    host_rd(6'd7, w);
    check_eq("erase_w7", 32'(w), 32'hFFFF);
    host_rd(6'd8, w);
    check_eq("erase_w8_kept", 32'(w), 32'h2222);

    // Reset plus host write during BUSY.
    send_cmd(2'b01, 6'd10, d);
    send_data(16'hCAFE, 16);
    bus.eep_cs = 1'b0;
    tick();
    check_eq("busy_started", 32'(bus.eep_rdy), 32'd0);
    repeat (99) tick();
    rst_n = 1'b0;
    bus.nv_addr = 6'd9;
    bus.nv_din = 16'h5555;
    bus.nv_we = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.nv_we = 1'b0;
    check_eq("rst_busy_rdy", 32'(bus.eep_rdy), 32'd1);
    host_rd(6'd9, w);
    check_eq("rst_host_w9", 32'(w), 32'h5555);
    host_rd(6'd10, w);
    check_eq("rst_w10_kept", 32'(w), 32'hCAFE);
    send_cmd(2'b01, 6'd10, d);
    send_data(16'h0000, 16);
    bus.eep_cs = 1'b0;
    wait_busy(lo, dl);
    check_eq("rst_ewen_clr", 32'(lo), 32'd0);
    host_rd(6'd10, w);
    check_eq("rst_w10_still", 32'(w), 32'hCAFE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtriders_eeprom.md
JTRIDERS_EEPROM -- requirements
Module: jtriders_eeprom

Interface
REQ-001 Parameter WR_CYCLES, default 2048: busy duration, in clk cycles, of any programming operation.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 eep_cs  in  1  chip select from the CPU latch; active high.
REQ-005 eep_sk  in  1  serial clock from the CPU latch; sampled by clk.
REQ-006 eep_di  in  1  serial data in.
REQ-007 eep_do  out  1  serial data out; feeds the cabinet input mux.
REQ-008 eep_rdy  out  1  1 = ready, 0 = programming busy; feeds the cabinet input mux.
REQ-009 nv_addr  in  6  host NVRAM load/save word address.
REQ-010 nv_din  in  16  host write data.
REQ-011 nv_we  in  1  host write strobe.
REQ-012 nv_dout  out  16  host read data, registered.

Function
REQ-013 Storage SHALL be 64 x 16-bit words, emulating a 93C46 in x16 organisation.
REQ-014 Rising SK edge: eep_sk=1 while its previous clk sample was 0 and eep_cs=1; every serial action SHALL occur in the clk cycle that detects it.
REQ-015 States: IDLE, CMD, READ, WDATA, BUSY.
REQ-016 IDLE: di=1 on an SK edge -> CMD with bit count 0; di=0 is ignored.
REQ-017 CMD: 8 bits SHALL be shifted MSB first as opcode[1:0], addr[5:0]; decoding SHALL occur on the 8th edge.
REQ-018 READ (10): on decode, eep_do=0 (dummy bit) and the word at addr is loaded.
REQ-019 READ: each later SK edge SHALL present the next bit, MSB first.
REQ-020 READ: after bit 0, the next edge SHALL present the MSB of addr+1 (6-bit wrap, 63 -> 0).
REQ-021 WRITE (01) and WRAL (00 01xxxx) SHALL go to WDATA and shift 16 data bits MSB first.
REQ-022 ERASE (11) and ERAL (00 10xxxx) SHALL arm a programming operation on decode.
REQ-023 EWEN (00 11xxxx) SHALL set the write-enable flag; EWDS (00 00xxxx) SHALL clear it; both -> IDLE.
REQ-024 Programming SHALL start on the first clk cycle that sees eep_cs=0 after an armed command, or after exactly 16 data bits in WDATA.
REQ-025 On programming start: WRITE stores data at addr; WRAL stores data in all 64 words; ERASE sets addr to 16'hFFFF; ERAL sets all 64 words to 16'hFFFF.
REQ-026 On programming start SHALL go to BUSY with eep_rdy=0 for exactly WR_CYCLES cycles, then eep_rdy=1 and IDLE.
REQ-027 Write-enable flag clear: programming commands SHALL be decoded then discarded with no memory change and no BUSY.
REQ-028 Fewer or more than 16 data bits before CS falls: the write SHALL be discarded.
REQ-029 eep_cs=0 in CMD, READ or WDATA SHALL abort to IDLE.
REQ-030 eep_do SHALL be 1 whenever not in READ.
REQ-031 During BUSY, all SK, DI and CS activity SHALL be ignored; eep_do SHALL stay 1.
REQ-032 Host port: nv_we=1 SHALL write nv_din to nv_addr that cycle.
REQ-033 nv_dout SHALL equal mem[nv_addr] one cycle after nv_addr is applied.
REQ-034 A host write and serial programming of the same cycle and word: the host write SHALL win.
REQ-035 Host writes SHALL be accepted in every state, BUSY included.

Reset
REQ-036 rst_n=0 SHALL force: state IDLE, write-enable 0, eep_do=1, eep_rdy=1, nv_dout=0, shift and bit counters 0, busy counter 0.
REQ-037 Memory contents SHALL NOT be altered by reset.
REQ-038 Reset asserted during BUSY SHALL cancel the remaining busy time; a programming operation already started SHALL keep its memory update.
REQ-039 Reset asserted mid-command SHALL drop the command.

Verification
REQ-040 Host writes 16'h1234 to addr 5; serial READ addr 5 -> eep_do: 0, then 0001_0010_0011_0100; 16 further edges -> word at addr 6.
REQ-041 EWEN; WRITE addr 3, data 16'hBEEF; CS low -> eep_rdy=0 for exactly 2048 cycles; host read addr 3 = 16'hBEEF.
REQ-042 After reset, no EWEN; WRITE addr 3, data 16'h0000 -> eep_rdy stays 1; addr 3 unchanged.
REQ-043 EWEN; ERAL -> all 64 words = 16'hFFFF after busy; READ addr 63 with 17 data edges -> bit 16 is the MSB of addr 0.
REQ-044 EWEN; WRITE addr 7 with only 10 data bits then CS low -> no busy, addr 7 unchanged; CS low after 4 command bits -> IDLE, next command decodes correctly.
REQ-045 EWEN; WRITE starts BUSY; host write 16'h5555 to addr 9 and reset at busy cycle 100 -> eep_rdy=1 next cycle, write-enable cleared, addr 9 = 16'h5555, WRITE data retained.
